mem_lsu: RTL and testbench

Initiator-side load/store unit for the MEM stage. It takes the memory operation from the EX/MEM pipeline register and drives a valid/ready request bus toward the data-memory responder. It handles byte/halfword/word sizing, write strobes, load sign/zero extension, misalignment and illegal-size detection, and a response timeout. It stalls the pipeline until each access completes.

---
 rtl/mem_lsu.sv | 132 +++++++++++++
 tb/tb_mem_lsu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: sizes, aligns and issues one data-memory access
// on a valid/ready bus, extends load data, and stalls the pipeline meanwhile.
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_memAddr,
  input  logic [31:0] i_writeData,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_ctrlMEM,
  output logic        o_req_valid,
  input  logic        i_req_ready,
  output logic [31:0] o_req_addr,
  output logic        o_req_we,
  output logic [3:0]  o_req_wstrb,
  output logic [31:0] o_req_wdata,
  input  logic        i_rsp_valid,
  input  logic [31:0] i_rsp_data,
  output logic [31:0] o_readData,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_misaligned,
  output logic        o_accessFault,
  output logic        o_busErr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        is_store, fault, misal, tmo;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c, shifted, ext;

  always_comb begin
    is_store = (i_ctrlMEM == 2'b01);
    fault    = (i_ctrlMEM == 2'b11) ||
               (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111) ||
               (is_store && (i_funct3 == 3'b100 || i_funct3 == 3'b101));
    misal    = ((i_funct3[1:0] == 2'b01) && i_memAddr[0]) ||
               ((i_funct3 == 3'b010) && (i_memAddr[1:0] != 2'b00));
    wstrb_c  = 4'b0000;
    wdata_c  = i_writeData;
    case (i_funct3[1:0])
      2'b00: begin
        wstrb_c = 4'b0001 << i_memAddr[1:0];
        wdata_c = {4{i_writeData[7:0]}};
      end
      2'b01: begin
        wstrb_c = 4'b0011 << {i_memAddr[1], 1'b0};
        wdata_c = {2{i_writeData[15:0]}};
      end
      default: wstrb_c = 4'b1111;
    endcase
    if (!is_store) wstrb_c = 4'b0000;
  end

  // Halfword lanes are always even, so a byte-granular shift serves both sizes.
  always_comb begin
    shifted = i_rsp_data >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'b0, shifted[7:0]};
      3'b101:  ext = {16'b0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    tmo      = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES - 1);
    state_nx = state;
    case (state)
      IDLE:     if (i_ctrlMEM != 2'b00) state_nx = (fault || misal) ? DONE : REQ;
      REQ:      if (i_req_ready) state_nx = o_req_we ? DONE : WAIT_RSP;
      WAIT_RSP: if (i_rsp_valid || tmo) state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
    o_req_valid = (state == REQ);
    o_done      = (state == DONE);
    o_stall     = (state == REQ) || (state == WAIT_RSP) ||
                  ((state == IDLE) && (i_ctrlMEM != 2'b00));
  end

  // Fault flags default low each edge so they are only visible in DONE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      f3_q          <= '0;
      lane_q        <= '0;
      o_req_addr    <= '0;
      o_req_we      <= 1'b0;
      o_req_wstrb   <= '0;
      o_req_wdata   <= '0;
      o_readData    <= '0;
      o_misaligned  <= 1'b0;
      o_accessFault <= 1'b0;
      o_busErr      <= 1'b0;
    end else begin
      state         <= state_nx;
      o_misaligned  <= 1'b0;
      o_accessFault <= 1'b0;
      o_busErr      <= 1'b0;
      case (state)
        IDLE: if (i_ctrlMEM != 2'b00) begin
          if (fault) o_accessFault <= 1'b1;
          else if (misal) o_misaligned <= 1'b1;
          else begin
            o_req_addr  <= {i_memAddr[31:2], 2'b00};
            o_req_we    <= is_store;
            o_req_wstrb <= wstrb_c;
            o_req_wdata <= wdata_c;
            f3_q        <= i_funct3;
            lane_q      <= i_memAddr[1:0];
          end
        end
        REQ: if (i_req_ready && !o_req_we) cnt <= '0;
        WAIT_RSP: begin
          if (i_rsp_valid) o_readData <= ext;
          else if (tmo) o_busErr <= 1'b1;
          else cnt <= cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stimulus pushes expected completions into a
// queue that a negedge monitor pops whenever o_done is seen.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr, write_data, req_addr, req_wdata, rsp_data, read_data;
  logic [2:0]  funct3;
  logic [1:0]  ctrl;
  logic        req_valid, req_ready, req_we, rsp_valid;
  logic [3:0]  req_wstrb;
  logic        stall, done, misaligned, access_fault, bus_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        af;
    logic        be;
  } exp_t;
  exp_t sb[$];

  mem_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_memAddr(mem_addr), .i_writeData(write_data),
    .i_funct3(funct3), .i_ctrlMEM(ctrl), .o_req_valid(req_valid),
    .i_req_ready(req_ready), .o_req_addr(req_addr), .o_req_we(req_we),
    .o_req_wstrb(req_wstrb), .o_req_wdata(req_wdata), .i_rsp_valid(rsp_valid),
    .i_rsp_data(rsp_data), .o_readData(read_data), .o_stall(stall), .o_done(done),
    .o_misaligned(misaligned), .o_accessFault(access_fault), .o_busErr(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_rdata", read_data, e.rd);
        chk("done_mis", {31'b0, misaligned}, {31'b0, e.mis});
        chk("done_af", {31'b0, access_fault}, {31'b0, e.af});
        chk("done_be", {31'b0, bus_err}, {31'b0, e.be});
        chk("done_stall", {31'b0, stall}, 32'd0);
      end
    end
  end

  // Called just after a rising edge with the DUT in IDLE; returns likewise.
  task automatic op(input string name, input logic [1:0] c, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input bit exp_req, input logic [31:0] raddr, input logic [3:0] rstrb,
                    input logic [31:0] rwdata, input int rdy_wait, input int rsp_wait,
                    input logic [31:0] rsp, input int exp_lat, input logic [31:0] exp_rd,
                    input logic emis, input logic eaf, input logic ebe);
    int cyc = 0, reqn = 0, waitn = 0;
    bit fin = 0, accepted = 0, hs, saw_req = 0;
    exp_t e;
    e.rd = exp_rd; e.mis = emis; e.af = eaf; e.be = ebe;
    sb.push_back(e);
    ctrl = c; funct3 = f3; mem_addr = a; write_data = wd;
    while (!fin && cyc < 60) begin
      @(negedge clk);
      cyc++;
      hs = 0;
      if (done) fin = 1;
      else begin
        chk({name, "_stall"}, {31'b0, stall}, 32'd1);
        if (req_valid) begin
          saw_req = 1;
          chk({name, "_addr"}, req_addr, raddr);
          chk({name, "_we"}, {31'b0, req_we}, {31'b0, (c == 2'b01)});
          chk({name, "_wstrb"}, {28'b0, req_wstrb}, {28'b0, rstrb});
          chk({name, "_wdata"}, req_wdata, rwdata);
          req_ready = (reqn >= rdy_wait);
          hs = req_ready;
          reqn++;
        end else begin
          req_ready = 1'b0;
          if (accepted) begin
            rsp_valid = (rsp_wait >= 0) && (waitn == rsp_wait);
            rsp_data  = rsp;
            waitn++;
          end
        end
        @(posedge clk);
        #1;
        ctrl = 2'b00; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
        if (hs) accepted = 1;
      end
    end
    chk({name, "_lat"}, cyc, exp_lat);
    chk({name, "_req"}, {31'b0, saw_req}, {31'b0, exp_req});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  localparam logic [31:0] RW = 32'h80FF_7F01;

  initial begin
    reset = 1; ctrl = 0; funct3 = 0; mem_addr = 0; write_data = 0;
    req_ready = 0; rsp_valid = 0; rsp_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_addr", req_addr, 32'd0);
    chk("rst_flags", {29'b0, misaligned, access_fault, bus_err}, 32'd0);
    @(posedge clk);
    #1 reset = 0;

    // stores
    op("sw", 2'b01, 3'b010, 32'h104, 32'hDEADBEEF, 1, 32'h104, 4'hF, 32'hDEADBEEF,
       0, -1, 0, 3, 32'h0, 0, 0, 0);
    op("sb", 2'b01, 3'b000, 32'h103, 32'h000000A5, 1, 32'h100, 4'h8, 32'hA5A5A5A5,
       4, -1, 0, 7, 32'h0, 0, 0, 0);
    op("sh", 2'b01, 3'b001, 32'h102, 32'h1234ABCD, 1, 32'h100, 4'hC, 32'hABCDABCD,
       0, -1, 0, 3, 32'h0, 0, 0, 0);
    // loads from one response word
    op("lb1", 2'b10, 3'b000, 32'h201, 0, 1, 32'h200, 4'h0, 0, 0, 0, RW, 4, 32'h0000007F, 0, 0, 0);
    op("lb3", 2'b10, 3'b000, 32'h203, 0, 1, 32'h200, 4'h0, 0, 0, 0, RW, 4, 32'hFFFFFF80, 0, 0, 0);
    op("lbu3", 2'b10, 3'b100, 32'h203, 0, 1, 32'h200, 4'h0, 0, 1, 0, RW, 5, 32'h00000080, 0, 0, 0);
    op("lhu2", 2'b10, 3'b101, 32'h202, 0, 1, 32'h200, 4'h0, 0, 0, 0, RW, 4, 32'h000080FF, 0, 0, 0);
    op("lh2", 2'b10, 3'b001, 32'h202, 0, 1, 32'h200, 4'h0, 0, 0, 0, RW, 4, 32'hFFFF80FF, 0, 0, 0);
    op("lw", 2'b10, 3'b010, 32'h200, 0, 1, 32'h200, 4'h0, 0, 0, 2, RW, 6, RW, 0, 0, 0);
    // faults: no bus request, readData held
    op("lw_mis", 2'b10, 3'b010, 32'h102, 0, 0, 0, 0, 0, 0, -1, 0, 2, RW, 1, 0, 0);
    op("lh_mis", 2'b10, 3'b001, 32'h201, 0, 0, 0, 0, 0, 0, -1, 0, 2, RW, 1, 0, 0);
    op("f3_011", 2'b10, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, -1, 0, 2, RW, 0, 1, 0);
    op("ctrl11", 2'b11, 3'b010, 32'h102, 0, 0, 0, 0, 0, 0, -1, 0, 2, RW, 0, 1, 0);
    op("st_bu", 2'b01, 3'b100, 32'h100, 0, 0, 0, 0, 0, 0, -1, 0, 2, RW, 0, 1, 0);
    // timeout: 16 WAIT_RSP cycles
    op("lw_tmo", 2'b10, 3'b010, 32'h300, 0, 1, 32'h300, 4'h0, 0, 0, -1, 0, 19, RW, 0, 0, 1);

    // a response while idle is ignored
    rsp_valid = 1; rsp_data = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rsp_done", {31'b0, done}, 32'd0);
      chk("idle_rsp_stall", {31'b0, stall}, 32'd0);
      chk("idle_rsp_rdata", read_data, RW);
    end
    @(posedge clk);
    #1 rsp_valid = 0;

    // reset while waiting for a response
    ctrl = 2'b10; funct3 = 3'b010; mem_addr = 32'h400; req_ready = 1;
    @(posedge clk);
    #1 ctrl = 2'b00;
    @(posedge clk);
    #1 req_ready = 0;
    chk("wait_valid", {31'b0, req_valid}, 32'd0);
    chk("wait_stall", {31'b0, stall}, 32'd1);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_valid", {31'b0, req_valid}, 32'd0);
      chk("mid_rst_rdata", read_data, 32'd0);
      chk("mid_rst_done", {31'b0, done}, 32'd0);
      chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
